// File: rtl/mem_access_unit_pkg.sv
// Shared memory-bus parameters and the access-unit state encoding.
// The word/address sizes are common with the memory array.
package mem_access_unit_pkg;

   localparam int WORD_SIZE      = 16;
   localparam int MEM_ADDR_SIZE  = 5;
   localparam int MEM_SIZE       = 32;
   localparam int CORE_ADDR_SIZE = 8;

   localparam logic [2:0] ST_IDLE_ENC       = 3'd0;
   localparam logic [2:0] ST_RD_ISSUE_ENC   = 3'd1;
   localparam logic [2:0] ST_RD_CAPTURE_ENC = 3'd2;
   localparam logic [2:0] ST_WR_ISSUE_ENC   = 3'd3;
   localparam logic [2:0] ST_RESP_ENC       = 3'd4;

   typedef enum logic [2:0] {
      IDLE       = ST_IDLE_ENC,
      RD_ISSUE   = ST_RD_ISSUE_ENC,
      RD_CAPTURE = ST_RD_CAPTURE_ENC,
      WR_ISSUE   = ST_WR_ISSUE_ENC,
      RESP       = ST_RESP_ENC
   } state_e;

   function automatic logic addr_in_range(input logic [CORE_ADDR_SIZE-1:0] addr);
      return addr < CORE_ADDR_SIZE'(MEM_SIZE);
   endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Core-side initiator for the single-port memory: one load/store at a time,
// absorbing the memory's one-cycle registered read latency.
module mem_access_unit
   import mem_access_unit_pkg::*;
(
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic                      req_write,
   input  logic [CORE_ADDR_SIZE-1:0] req_addr,
   input  logic [WORD_SIZE-1:0]      req_wdata,
   output logic                      resp_valid,
   input  logic                      resp_ready,
   output logic [WORD_SIZE-1:0]      resp_data,
   output logic                      resp_error,
   output logic                      mem_read_enable,
   output logic                      mem_write_enable,
   output logic [MEM_ADDR_SIZE-1:0]  mem_address,
   output logic [WORD_SIZE-1:0]      mem_data_in,
   input  logic [WORD_SIZE-1:0]      mem_data_out
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid, once raised, holds its payload stable until that edge.

   state_e                     state_q, state_d;
   logic                       resp_valid_q, resp_valid_d;
   logic                       resp_error_q, resp_error_d;
   logic [WORD_SIZE-1:0]       resp_data_q, resp_data_d;
   logic                       mem_read_enable_q, mem_read_enable_d;
   logic                       mem_write_enable_q, mem_write_enable_d;
   logic [MEM_ADDR_SIZE-1:0]   mem_address_q, mem_address_d;
   logic [WORD_SIZE-1:0]       mem_data_in_q, mem_data_in_d;

   always_comb begin
      state_d            = state_q;
      resp_valid_d       = resp_valid_q;
      resp_error_d       = resp_error_q;
      resp_data_d        = resp_data_q;
      mem_read_enable_d  = 1'b0;
      mem_write_enable_d = 1'b0;
      mem_address_d      = mem_address_q;
      mem_data_in_d      = mem_data_in_q;
      unique case (state_q)
         IDLE: begin
            if (req_valid) begin
               // Range check uses the full core address before truncation.
               if (!addr_in_range(req_addr)) begin
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
                  resp_data_d  = '0;
                  state_d      = RESP;
               end else if (req_write) begin
                  mem_address_d      = req_addr[MEM_ADDR_SIZE-1:0];
                  mem_data_in_d      = req_wdata;
                  mem_write_enable_d = 1'b1;
                  state_d            = WR_ISSUE;
               end else begin
                  mem_address_d     = req_addr[MEM_ADDR_SIZE-1:0];
                  mem_read_enable_d = 1'b1;
                  state_d           = RD_ISSUE;
               end
            end
         end
         RD_ISSUE: state_d = RD_CAPTURE;
         RD_CAPTURE: begin
            resp_data_d  = mem_data_out;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            state_d      = RESP;
         end
         WR_ISSUE: begin
            resp_data_d  = '0;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b0;
            state_d      = RESP;
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q            <= IDLE;
         resp_valid_q       <= 1'b0;
         resp_error_q       <= 1'b0;
         resp_data_q        <= '0;
         mem_read_enable_q  <= 1'b0;
         mem_write_enable_q <= 1'b0;
         mem_address_q      <= '0;
         mem_data_in_q      <= '0;
      end else begin
         state_q            <= state_d;
         resp_valid_q       <= resp_valid_d;
         resp_error_q       <= resp_error_d;
         resp_data_q        <= resp_data_d;
         mem_read_enable_q  <= mem_read_enable_d;
         mem_write_enable_q <= mem_write_enable_d;
         mem_address_q      <= mem_address_d;
         mem_data_in_q      <= mem_data_in_d;
      end
   end

   assign req_ready        = (state_q == IDLE);
   assign resp_valid       = resp_valid_q;
   assign resp_error       = resp_error_q;
   assign resp_data        = resp_data_q;
   assign mem_read_enable  = mem_read_enable_q;
   assign mem_write_enable = mem_write_enable_q;
   assign mem_address      = mem_address_q;
   assign mem_data_in      = mem_data_in_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the single-port data/instruction memory bus. It accepts one load or store request at a time from the CPU core over a valid/ready handshake and drives the memory strobes, address and write data. It absorbs the memory's one-cycle registered read latency and returns read data or a write acknowledgement over a valid/ready response channel. It sits between the core datapath and the memory array.

Parameters:
WORD_SIZE, 16, data word width in bits (shared package)
MEM_ADDR_SIZE, 5, memory address width (shared package)
MEM_SIZE, 32, number of memory words (shared package)
CORE_ADDR_SIZE, 8, width of the core-side address; addresses >= MEM_SIZE are out of range

Ports:
clock  input  1  system clock; all state updates on its rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  1  core request present
req_ready  output  1  unit can accept a request
req_write  input  1  1 = store, 0 = load
req_addr  input  CORE_ADDR_SIZE  word address
req_wdata  input  WORD_SIZE  store data
resp_valid  output  1  response present
resp_ready  input  1  core consumes the response
resp_data  output  WORD_SIZE  load data; 0 for stores and errors
resp_error  output  1  out-of-range access flag
mem_read_enable  output  1  memory read strobe
mem_write_enable  output  1  memory write strobe
mem_address  output  MEM_ADDR_SIZE  memory address
mem_data_in  output  WORD_SIZE  data to memory
mem_data_out  input  WORD_SIZE  registered read data from memory

Behaviour:
- Reset (synchronous, active-high): state=IDLE; resp_valid=0, resp_error=0, resp_data=0; mem_read_enable=0, mem_write_enable=0, mem_address=0, mem_data_in=0. Reset is synchronous and active-high and overrides every state.
- All outputs are registered except req_ready, which equals (state==IDLE).
- States are IDLE, RD_ISSUE, RD_CAPTURE, WR_ISSUE and RESP.
- IDLE: a handshake (req_valid && req_ready) at edge E0 latches the request.
  - Out-of-range address (req_addr >= MEM_SIZE): go to RESP with resp_error=1 and resp_data=0. No memory strobe is raised.
  - Load: mem_address = req_addr[MEM_ADDR_SIZE-1:0], mem_read_enable=1, go to RD_ISSUE.
  - Store: mem_address as for a load, mem_data_in = req_wdata, mem_write_enable=1, go to WR_ISSUE.
- RD_ISSUE: memory samples at E1. The unit drops mem_read_enable at E1 and goes to RD_CAPTURE.
- RD_CAPTURE: at E2 the unit latches resp_data = mem_data_out, sets resp_valid=1 and resp_error=0, and goes to RESP. Load response latency is 2 cycles from the acceptance edge.
- WR_ISSUE: memory writes at E1. The unit drops mem_write_enable and sets resp_valid=1, resp_data=0 and resp_error=0, then goes to RESP. Store ack latency is 1 cycle.
- RESP: resp_valid, resp_data and resp_error stay stable until resp_ready is high on a rising edge. At that edge resp_valid drops to 0 and the state goes to IDLE.
  - req_ready is low throughout RESP, so there is never more than one outstanding access.
  - A new request can be accepted no earlier than the cycle after the response is consumed.
- Strobes are never asserted together, and each stays high for exactly one cycle per access.
- mem_address and mem_data_in hold their last values when no access is active.
- In IDLE, req_write, req_addr and req_wdata are ignored unless req_valid is high.
- Reset during RD_ISSUE or WR_ISSUE deasserts the strobe at that same edge. The in-flight response is discarded and resp_valid stays 0.
- Address truncation takes the low MEM_ADDR_SIZE bits, and happens only after the range check has passed.

Decomposition:
- WORD_SIZE, MEM_ADDR_SIZE and MEM_SIZE come from the shared parameters include, which is common with the memory array.
- Add CORE_ADDR_SIZE and the state encodings (IDLE=0, RD_ISSUE=1, RD_CAPTURE=2, WR_ISSUE=3, RESP=4, in a 3-bit localparam set) to the same shared include.
- No sub-module. Single FSM plus registered outputs.

Test Plan:
- Store then load: store addr 5, data 16'hA5C3, ack after 1 cycle; load addr 5 returns resp_data=16'hA5C3, resp_error=0, resp_valid 2 cycles after acceptance.
- Backpressure: load with resp_ready=0 for 4 cycles -> resp_valid and resp_data stable; req_ready=0 throughout; a req_valid held high is accepted only the cycle after resp_ready=1.
- Out of range: load addr 8'd40 -> resp_error=1, resp_data=0, no mem_read_enable pulse; store addr 8'd32 -> resp_error=1, no mem_write_enable pulse.
- Boundaries: store 16'hFFFF at addr 31 and 16'h0001 at addr 0, read both back -> values intact, no aliasing.
- Reset mid-operation: assert reset in the RD_ISSUE cycle -> next cycle all strobes=0, resp_valid=0, req_ready=1; a subsequent load of any address returns 0 because the memory is also cleared.
- Back-to-back stores to addrs 0..31 with resp_ready tied to 1 -> exactly one mem_write_enable pulse per request, spaced 3 cycles apart; readback matches.
